// File: rtl/pueo_uram_buffer.sv
`timescale 1ns/1ps
// Circular 96-bit sample buffer with an AXI4-Stream windowed readback re-packed into 72-bit beats.
// Optional build macro PUEO_URAM_SYNC_EN holds off writing until the first aclk_sync_i pulse.
module pueo_uram_buffer #(
    parameter int ADDR_BITS  = 10,
    parameter int READ_WORDS = 48
) (
    input  logic                 aclk,
    input  logic                 aclk_rst_i,
    input  logic                 aclk_sync_i,
    input  logic [95:0]          dat_i,
    output logic [ADDR_BITS-1:0] wr_addr_o,
    input  logic [15:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [71:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int BEATS  = READ_WORDS * 4 / 3;
    localparam int CAP    = 32;
    localparam int GBX_W  = CAP * 12;
    localparam int WCNT_W = $clog2(READ_WORDS + 1);
    localparam int BCNT_W = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_nxt;
    logic                  wr_en;
    logic [95:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0]  rd_addr, rd_ptr;
    logic [95:0]           s1_data, s2_data;
    logic                  a_valid, s1_valid, s2_valid;
    logic [WCNT_W-1:0]     words_issued;
    logic [BCNT_W-1:0]     beat_cnt;
    logic [GBX_W-1:0]      gbx_data, avail;
    logic [5:0]            gbx_cnt, avail_cnt;
    logic [8:0]            shamt;
    logic [6:0]            pending;
    logic                  accept, issue, emit, out_free, can_issue;

`ifdef PUEO_URAM_SYNC_EN
    logic wr_run;
    logic unused_bits;
    assign unused_bits = ^s_axis_tdata[15:ADDR_BITS];

    always_ff @(posedge aclk) begin
        if (aclk_rst_i)
            wr_run <= 1'b0;
        else if (aclk_sync_i)
            wr_run <= 1'b1;
    end

    assign wr_en = !aclk_rst_i && (wr_run || aclk_sync_i);
`else
    logic unused_bits;
    assign unused_bits = ^{s_axis_tdata[15:ADDR_BITS], aclk_sync_i};
    assign wr_en = !aclk_rst_i;
`endif

    always_ff @(posedge aclk) begin
        if (aclk_rst_i)
            wr_addr_o <= '0;
        else if (wr_en)
            wr_addr_o <= wr_addr_o + 1'b1;
    end

    // Read-before-write RAM with a second output register, as a URAM cascade would have.
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_addr_o] <= dat_i;
        s1_data <= mem[rd_addr];
        s2_data <= s1_data;
    end

    assign s_axis_tready = (state == IDLE) && !aclk_rst_i;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_free      = !m_axis_tvalid || m_axis_tready;

    // The gearbox appends the arriving word behind whatever samples are already queued.
    always_comb begin
        shamt     = 9'(gbx_cnt) * 9'd12;
        avail     = gbx_data;
        avail_cnt = gbx_cnt;
        if (s2_valid) begin
            avail     = gbx_data | ({{(GBX_W-96){1'b0}}, s2_data} << shamt);
            avail_cnt = gbx_cnt + 6'd8;
        end
        emit = out_free && (avail_cnt >= 6'd6);
    end

    // Every word in flight is already reserved in the gearbox, so stalls can never overflow it.
    always_comb begin
        pending = 7'(gbx_cnt) + (a_valid ? 7'd8 : 7'd0) + (s1_valid ? 7'd8 : 7'd0)
                + (s2_valid ? 7'd8 : 7'd0);
        can_issue = (pending + 7'd8) <= (7'(CAP) + (emit ? 7'd6 : 7'd0));
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = READ;
            end
            READ: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (words_issued == WCNT_W'(READ_WORDS - 1))
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst_i) begin
            state         <= IDLE;
            a_valid       <= 1'b0;
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            rd_addr       <= '0;
            rd_ptr        <= '0;
            words_issued  <= '0;
            beat_cnt      <= '0;
            gbx_data      <= '0;
            gbx_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_valid  <= issue;
            s1_valid <= a_valid;
            s2_valid <= s1_valid;
            if (accept) begin
                rd_ptr       <= s_axis_tdata[ADDR_BITS-1:0];
                words_issued <= '0;
                beat_cnt     <= '0;
            end else if (issue) begin
                rd_addr      <= rd_ptr;
                rd_ptr       <= rd_ptr + 1'b1;
                words_issued <= words_issued + 1'b1;
            end
            if (emit) begin
                gbx_data      <= avail >> 72;
                gbx_cnt       <= avail_cnt - 6'd6;
                m_axis_tdata  <= avail[71:0];
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (beat_cnt == BCNT_W'(BEATS - 1));
                beat_cnt      <= beat_cnt + 1'b1;
            end else begin
                gbx_data <= avail;
                gbx_cnt  <= avail_cnt;
                if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pueo_uram_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for pueo_uram_buffer: ramp writes, windowed reads, backpressure, wrap and reset abort.
module tb_pueo_uram_buffer;

    localparam int BEATS = 64;
`ifdef PUEO_URAM_SYNC_EN
    localparam int SYNC_OFF = 5;
`else
    localparam int SYNC_OFF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic [95:0] dat;
    logic [9:0]  wr_addr;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [71:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    logic [72:0] sb_q[$];
    logic [72:0] prev_out;
    logic        prev_stall = 1'b0;

    pueo_uram_buffer dut (
        .aclk         (clk),
        .aclk_rst_i   (rst),
        .aclk_sync_i  (sync),
        .dat_i        (dat),
        .wr_addr_o    (wr_addr),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] ramp(input int n);
        logic [95:0] w;
        for (int j = 0; j < 8; j++)
            w[12*j +: 12] = 12'((8*n + j) % 4096);
        return w;
    endfunction

    function automatic logic [71:0] exp_beat(input int n0, input int b);
        logic [71:0] w;
        for (int i = 0; i < 6; i++)
            w[12*i +: 12] = 12'((8*n0 + 6*b + i) % 4096);
        return w;
    endfunction

    function automatic logic [9:0] exp_wa(input int c);
        if (c <= SYNC_OFF)
            return 10'd0;
        return 10'((c - SYNC_OFF) % 1024);
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out", name);
    endtask

    // One clock: cyc counts cycles since reset release and sets the ramp word for this cycle.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = rst;
        #1;
        if (r)
            cyc = 0;
        else
            cyc++;
        dat  = ramp(cyc);
        sync = (cyc == 5);
    endtask

    task automatic applyStimulus(input logic [15:0] start, input int n0, input bit toggle, input bit count_cycles);
        int n;
        for (int b = 0; b < BEATS; b++)
            sb_q.push_back({(b == BEATS-1) ? 1'b1 : 1'b0, exp_beat(n0, b)});
        m_tready = 1'b1;
        s_tdata  = start;
        s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 20) begin
            tick();
            n++;
        end
        if (!s_tready)
            timeoutFail("req_accept");
        tick();
        s_tvalid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("busy_tready", 96'(s_tready), 96'd0);
        checkOutput("latency_pre", 96'(m_tvalid), 96'd0);
        tick();
        checkOutput("latency_first", 96'(m_tvalid), 96'd1);
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            if (toggle)
                m_tready = ~m_tready;
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            timeoutFail("burst_done");
            sb_q.delete();
        end else if (count_cycles) begin
            checkOutput("burst_cycles", 96'(n), 96'd64);
        end
        checkOutput("idle_tready", 96'(s_tready), 96'd1);
        m_tready = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks held outputs during stalls.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 96'(m_tvalid), 96'd1);
                checkOutput("stall_hold", 96'({m_tlast, m_tdata}), 96'(prev_out));
            end
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    timeoutFail("unexpected_beat");
                end else begin
                    checkOutput($sformatf("beat%0d", beats_seen), 96'({m_tlast, m_tdata}), 96'(sb_q.pop_front()));
                    beats_seen++;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tlast, m_tdata};
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;
        dat = ramp(0);
        tick();
        tick();
        checkOutput("rst_tready", 96'(s_tready), 96'd0);
        checkOutput("rst_tvalid", 96'(m_tvalid), 96'd0);
        checkOutput("rst_tlast", 96'(m_tlast), 96'd0);
        checkOutput("rst_tdata", 96'(m_tdata), 96'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_tready", 96'(s_tready), 96'd1);
        checkOutput("rel_wr_addr", 96'(wr_addr), 96'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("wr_addr_c%0d", cyc), 96'(wr_addr), 96'(exp_wa(cyc)));
        end

        while (cyc < 200)
            tick();
        $display("[TB] basic readout start=16");
        applyStimulus(16'd16, 16 + SYNC_OFF, 1'b0, 1'b1);
        checkOutput("wr_addr_run", 96'(wr_addr), 96'(exp_wa(cyc)));

        $display("[TB] backpressure readout start=16");
        applyStimulus(16'd16, 16 + SYNC_OFF, 1'b1, 1'b0);

        while (cyc < 1100)
            tick();
        $display("[TB] wrap readout start=1014");
        applyStimulus(16'hFC00 | 16'd1014, 1014 + SYNC_OFF, 1'b0, 1'b1);

        $display("[TB] mid-request reset");
        for (int b = 0; b < BEATS; b++)
            sb_q.push_back({(b == BEATS-1) ? 1'b1 : 1'b0, exp_beat(100 + SYNC_OFF, b)});
        s_tdata  = 16'd100;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        base = beats_seen;
        n = 0;
        while (beats_seen - base < 20 && n < 200) begin
            tick();
            n++;
        end
        if (beats_seen - base < 20)
            timeoutFail("abort_beat20");
        rst = 1'b1;
        sb_q.delete();
        s_tdata  = 16'd0;
        s_tvalid = 1'b1;
        tick();
        checkOutput("abort_tvalid", 96'(m_tvalid), 96'd0);
        checkOutput("abort_tready", 96'(s_tready), 96'd0);
        rst = 1'b0;
        s_tvalid = 1'b0;
        #1;
        checkOutput("rst_req_ignored", 96'(s_tready), 96'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("wr_addr2_c%0d", cyc), 96'(wr_addr), 96'(exp_wa(cyc)));
        end
        checkOutput("post_rst_idle", 96'(m_tvalid), 96'd0);

        while (cyc < 80)
            tick();
        $display("[TB] readout start=0 after reset");
        applyStimulus(16'd0, SYNC_OFF, 1'b0, 1'b1);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
